// File: rtl/mini_core_fetch_q.sv
// -----------------------------------------------------------------------------
// mini_core_fetch_q
//
// Instruction fetch queue between the IF stage and decode. Each {PC, inst}
// response from instruction memory (Q101H) is pushed into a small circular
// FIFO and presented to decode through a valid/ready handshake. A credit
// scheme (queue occupancy plus the one possible in-flight fetch) drives a
// registered-state-only fetch-ready back to IF, so a response always has a
// slot waiting for it. A Q102H redirect empties the queue and squashes the
// fetch in flight.
//
// Ports
//   Clock            in   clock, all state on rising edge
//   Rst              in   asynchronous reset, active low
//   FlushQ102H       in   redirect taken in Q102H
//   FetchReadyQ100H  out  IF may issue a fetch this cycle
//   FetchValidQ101H  in   memory response valid
//   PcQ101H          in   response PC
//   InstQ101H        in   response instruction
//   DecValidQ101H    out  queue head valid toward decode
//   DecPcQ101H       out  head PC
//   DecInstQ101H     out  head instruction
//   DecReadyQ101H    in   decode accepts the head this cycle
//   CountQ           out  occupancy (log2(DEPTH)+1 bits)
//   ErrQ             out  sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module mini_core_fetch_q #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          FlushQ102H,
  output logic          FetchReadyQ100H,
  input  logic          FetchValidQ101H,
  input  logic [31:0]   PcQ101H,
  input  logic [31:0]   InstQ101H,
  output logic          DecValidQ101H,
  output logic [31:0]   DecPcQ101H,
  output logic [31:0]   DecInstQ101H,
  input  logic          DecReadyQ101H,
  output logic [PW-1:0] CountQ,
  output logic          ErrQ
);

  // Pointers carry one extra wrap bit so full (DEPTH) and empty (0) differ.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic          flush_shadow_q;
  logic          err_q, err_d;
  logic [63:0]   mem_q [DEPTH];

  logic [PW-1:0] count;
  logic [PW:0]   credit_used;
  logic          full;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          resp_unexpected;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign credit_used = {1'b0, count} + {{PW{1'b0}}, inflight_q};
  assign full        = (count == PW'(DEPTH));

  // Built only from registered state and reset: no path from decode-ready or
  // the memory response, which keeps IF timing independent of decode.
  assign FetchReadyQ100H = Rst & (credit_used < (PW + 1)'(DEPTH));

  assign push_req = FetchValidQ101H & inflight_q & ~FlushQ102H;
  // Credits make a push into a full queue impossible in correct operation;
  // if it ever happens the entry is refused rather than overwriting the head.
  assign push_ok  = push_req & ~full;
  assign pop      = DecValidQ101H & DecReadyQ101H & ~FlushQ102H;

  // A response without an outstanding fetch is an error, except the one
  // arriving the cycle after a flush: that is the squashed wrong-path fetch.
  assign resp_unexpected = FetchValidQ101H & ~inflight_q & ~flush_shadow_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = FetchReadyQ100H & ~FlushQ102H;
    err_d      = err_q | resp_unexpected | (push_req & full);
    if (FlushQ102H) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      inflight_q     <= 1'b0;
      flush_shadow_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      inflight_q     <= inflight_d;
      flush_shadow_q <= FlushQ102H;
      err_q          <= err_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read while the
  // pointers say they hold valid data, so resetting them buys nothing.
  always_ff @(posedge Clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {PcQ101H, InstQ101H};
  end

  assign DecValidQ101H = (count != '0);
  assign DecPcQ101H    = mem_q[rd_ptr_q[AW-1:0]][63:32];
  assign DecInstQ101H  = mem_q[rd_ptr_q[AW-1:0]][31:0];
  assign CountQ        = count;
  assign ErrQ          = err_q;

endmodule

// File: tb/tb_mini_core_fetch_q.sv
// -----------------------------------------------------------------------------
// tb_mini_core_fetch_q
//
// Bench for mini_core_fetch_q. The bench plays IF plus a 1-cycle instruction
// memory and keeps a queue-based reference model of what decode should see.
// -----------------------------------------------------------------------------
module tb_mini_core_fetch_q;
  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Rst;
  logic        FlushQ102H;
  logic        FetchReadyQ100H;
  logic        FetchValidQ101H;
  logic [31:0] PcQ101H;
  logic [31:0] InstQ101H;
  logic        DecValidQ101H;
  logic [31:0] DecPcQ101H;
  logic [31:0] DecInstQ101H;
  logic        DecReadyQ101H;
  logic [2:0]  CountQ;
  logic        ErrQ;

  mini_core_fetch_q #(.DEPTH(DEPTH)) dut (
    .Clock           (Clock),
    .Rst             (Rst),
    .FlushQ102H      (FlushQ102H),
    .FetchReadyQ100H (FetchReadyQ100H),
    .FetchValidQ101H (FetchValidQ101H),
    .PcQ101H         (PcQ101H),
    .InstQ101H       (InstQ101H),
    .DecValidQ101H   (DecValidQ101H),
    .DecPcQ101H      (DecPcQ101H),
    .DecInstQ101H    (DecInstQ101H),
    .DecReadyQ101H   (DecReadyQ101H),
    .CountQ          (CountQ),
    .ErrQ            (ErrQ)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  // Reference model: what decode should see, and the IF/memory side.
  logic [63:0] exp_q[$];
  bit          exp_inflight;
  bit          exp_err;
  bit          exp_flush_prev;
  bit          resp_pending;
  logic [31:0] resp_pc;
  logic [31:0] if_pc;
  logic [31:0] flush_target;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // One clock cycle: drive this cycle's inputs, compare all outputs against
  // the model, advance the model and IF, then move to just after the edge.
  task automatic tick(input bit flush, input bit dr, input bit inject);
    bit          fv, ready_m, issue, push, pop;
    logic [2:0]  exp_cnt;
    logic [63:0] head;
    fv              = resp_pending | inject;
    FetchValidQ101H = fv;
    PcQ101H         = resp_pending ? resp_pc : 32'hDEAD_0000;
    InstQ101H       = inst_of(PcQ101H);
    FlushQ102H      = flush;
    DecReadyQ101H   = dr;
    #1;
    ready_m = (exp_q.size() + int'(exp_inflight)) < DEPTH;
    exp_cnt = 3'(exp_q.size());
    tests++;
    if (CountQ !== exp_cnt) begin
      fails++; $display("FAIL count: got %0d exp %0d @%0t", CountQ, exp_cnt, $time);
    end
    tests++;
    if (DecValidQ101H !== (exp_q.size() != 0)) begin
      fails++; $display("FAIL dec_valid: got %0b exp %0b @%0t", DecValidQ101H, exp_q.size() != 0, $time);
    end
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      tests++;
      if ({DecPcQ101H, DecInstQ101H} !== head) begin
        fails++; $display("FAIL dec_data: got %h_%h exp %h @%0t", DecPcQ101H, DecInstQ101H, head, $time);
      end
    end
    tests++;
    if (FetchReadyQ100H !== ready_m) begin
      fails++; $display("FAIL fetch_ready: got %0b exp %0b @%0t", FetchReadyQ100H, ready_m, $time);
    end
    tests++;
    if (ErrQ !== exp_err) begin
      fails++; $display("FAIL err: got %0b exp %0b @%0t", ErrQ, exp_err, $time);
    end
    issue = FetchReadyQ100H;
    push  = fv & exp_inflight & ~flush;
    pop   = (exp_q.size() != 0) & dr & ~flush;
    if (fv && !exp_inflight && !exp_flush_prev) exp_err = 1'b1;
    if (push && exp_q.size() == DEPTH) exp_err = 1'b1;
    if (flush) exp_q.delete();
    else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back({PcQ101H, InstQ101H});
    end
    exp_inflight   = ready_m & ~flush;
    exp_flush_prev = flush;
    resp_pending   = issue;
    resp_pc        = if_pc;
    if (flush)      if_pc = flush_target;
    else if (issue) if_pc = if_pc + 32'd4;
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_inflight   = 1'b0;
    exp_err        = 1'b0;
    exp_flush_prev = 1'b0;
    resp_pending   = 1'b0;
    resp_pc        = '0;
    if_pc          = '0;
  endtask

  // Asserts reset (asynchronously, mid-cycle), checks outputs clear at once,
  // then releases away from the clock edge.
  task automatic do_reset();
    Rst = 1'b0;
    FlushQ102H = 1'b0; FetchValidQ101H = 1'b0; DecReadyQ101H = 1'b0;
    PcQ101H = '0; InstQ101H = '0;
    #1;
    tests++;
    if (CountQ !== 3'd0 || DecValidQ101H !== 1'b0 || ErrQ !== 1'b0 || FetchReadyQ100H !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got cnt=%0d val=%0b err=%0b rdy=%0b exp 0 0 0 0", CountQ, DecValidQ101H, ErrQ, FetchReadyQ100H);
    end
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Rst = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  // Ticks with decode stalled until CountQ reaches n; bounded.
  task automatic fill_to(input int n, input string tag);
    int guard = 0;
    while (CountQ != 3'(n) && guard < 20) begin
      tick(1'b0, 1'b0, 1'b0);
      guard++;
    end
    tests++;
    if (CountQ != 3'(n)) begin
      fails++; $display("FAIL %s_fill: got count %0d exp %0d", tag, CountQ, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (FetchReadyQ100H !== 1'b1 || CountQ !== 3'd0 || DecValidQ101H !== 1'b0) begin
      fails++; $display("FAIL after_reset: got rdy=%0b cnt=%0d val=%0b exp 1 0 0", FetchReadyQ100H, CountQ, DecValidQ101H);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (c >= 1 && c < 17) begin
        // Cycle c+1 after reset release should show PC 4*(c-1).
        tests++;
        if (DecValidQ101H !== 1'b1 || DecPcQ101H !== 32'((c - 1) * 4)) begin
          fails++; $display("FAIL stream_pc: got val=%0b pc=%h exp pc=%h", DecValidQ101H, DecPcQ101H, 32'((c - 1) * 4));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    tests++;
    if (CountQ !== 3'd4 || FetchReadyQ100H !== 1'b0 || DecPcQ101H !== 32'h0) begin
      fails++; $display("FAIL stall_full: got cnt=%0d rdy=%0b pc=%h exp 4 0 0", CountQ, FetchReadyQ100H, DecPcQ101H);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (DecPcQ101H !== 32'(i * 4)) begin
        fails++; $display("FAIL stall_drain: got %h exp %h", DecPcQ101H, 32'(i * 4));
      end
      tick(1'b0, 1'b1, 1'b0);
    end
    repeat (6) tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    do_reset();
    fill_to(3, "flush");
    flush_target = 32'h100;
    tests++;
    if (FetchValidQ101H !== 1'b1) begin
      fails++; $display("FAIL flush_setup: got resp_valid %0b exp 1", FetchValidQ101H);
    end
    tick(1'b1, 1'b0, 1'b0);  // cycle F, response in flight is dropped
    tests++;
    if (CountQ !== 3'd0 || DecValidQ101H !== 1'b0 || FetchReadyQ100H !== 1'b1) begin
      fails++; $display("FAIL flush_next: got cnt=%0d val=%0b rdy=%0b exp 0 0 1", CountQ, DecValidQ101H, FetchReadyQ100H);
    end
    tick(1'b0, 1'b0, 1'b0);  // F+1
    tick(1'b0, 1'b0, 1'b0);  // F+2
    tests++;
    if (DecValidQ101H !== 1'b1 || DecPcQ101H !== 32'h100 || ErrQ !== 1'b0) begin
      fails++; $display("FAIL flush_target: got val=%0b pc=%h err=%0b exp 1 100 0", DecValidQ101H, DecPcQ101H, ErrQ);
    end
    repeat (4) tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_to(2, "b2b");
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      tests++;
      if (CountQ !== 3'd2) begin
        fails++; $display("FAIL b2b_count: got %0d exp 2", CountQ);
      end
    end
  endtask

  task automatic test_err();
    do_reset();
    repeat (6) tick(1'b0, 1'b0, 1'b0);  // full, so no fetch is outstanding
    tick(1'b0, 1'b0, 1'b0);
    tests++;
    if (resp_pending) begin
      fails++; $display("FAIL err_setup: got pending 1 exp 0");
    end
    tick(1'b0, 1'b0, 1'b1);  // unsolicited response
    tests++;
    if (ErrQ !== 1'b1 || CountQ !== 3'd4) begin
      fails++; $display("FAIL err_set: got err=%0b cnt=%0d exp 1 4", ErrQ, CountQ);
    end
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    tests++;
    if (ErrQ !== 1'b1) begin
      fails++; $display("FAIL err_sticky: got %0b exp 1", ErrQ);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_to(3, "rstmid");
    do_reset();
    repeat (2) tick(1'b0, 1'b1, 1'b0);
    tests++;
    if (DecValidQ101H !== 1'b1 || DecPcQ101H !== 32'h0) begin
      fails++; $display("FAIL rstmid_restart: got val=%0b pc=%h exp 1 0", DecValidQ101H, DecPcQ101H);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit fl;
      fl = ($urandom_range(0, 19) == 0);
      if (fl) flush_target = {$urandom_range(0, 255), 2'b00} + 32'h1000;
      tick(fl, ($urandom_range(0, 2) != 0), 1'b0);
    end
  endtask

  initial begin
    Rst = 1'b0;
    FlushQ102H = 1'b0; FetchValidQ101H = 1'b0; DecReadyQ101H = 1'b0;
    PcQ101H = '0; InstQ101H = '0; flush_target = '0;
    model_reset();
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mini_core_fetch_q.md
# mini_core_fetch_q

Instruction fetch queue for mini_core, directly downstream of the IF stage. Captures each {PC, instruction} pair returned by instruction memory in Q101H into a small circular FIFO and presents it to decode through a valid/ready handshake. Issues a registered, credit-based fetch-ready back to IF and discards all queued and in-flight entries on a Q102H redirect.

## Interface
- DEPTH, 4, number of queue entries; power of two, DEPTH >= 2
- Clock  in  1  single clock, all state on rising edge
- Rst  in  1  asynchronous, active-low reset (low = reset asserted)
- FlushQ102H  in  1  redirect taken in Q102H (same condition that makes IF select AluOutQ102H)
- FetchReadyQ100H  out  1  IF may advance PC and issue a fetch this cycle; drives IF ReadyQ100H/ReadyQ101H
- FetchValidQ101H  in  1  instruction memory response valid this cycle
- PcQ101H  in  32  PC of the response
- InstQ101H  in  32  instruction word of the response
- DecValidQ101H  out  1  queue head valid toward decode
- DecPcQ101H  out  32  head PC
- DecInstQ101H  out  32  head instruction
- DecReadyQ101H  in  1  decode accepts head this cycle
- CountQ  out  log2(DEPTH)+1  registered occupancy
- ErrQ  out  1  sticky error: response received with no credit outstanding, or push into full queue

## Operation
- Storage: DEPTH x 64-bit entries {Pc, Inst}; WrPtr/RdPtr are log2(DEPTH)+1 bits, wrap naturally; Count = WrPtr - RdPtr.
- InflightQ: 1-bit register, set when a fetch is issued (FetchReadyQ100H=1), cleared otherwise. Memory latency is fixed at 1 cycle: every issued fetch returns exactly one FetchValidQ101H the next cycle.
- FetchReadyQ100H = (CountQ + InflightQ) < DEPTH, computed from registered state only; no combinational path from DecReadyQ101H or FetchValidQ101H. Forced 0 while Rst is asserted.
- Push: FetchValidQ101H & InflightQ & ~FlushQ102H. Entry written at WrPtr, WrPtr+1.
- Pop: DecValidQ101H & DecReadyQ101H & ~FlushQ102H. RdPtr+1.
- Simultaneous push and pop: both take effect, Count unchanged. Push and pop with Count==0 does not bypass; the pushed entry becomes visible next cycle.
- DecValidQ101H = (CountQ != 0). DecPc/DecInst = entry[RdPtr]; when invalid they hold the last array value and are don't-care.
- Flush (FlushQ102H=1): at next edge WrPtr=RdPtr=0, InflightQ=0, and the FetchValidQ101H response of the flush cycle is dropped. The fetch issued in the flush cycle is wrong-path and is squashed by clearing InflightQ; its response, if any, arrives with InflightQ=0 and is dropped without raising ErrQ.
- ErrQ sets on FetchValidQ101H & ~InflightQ & ~flush-shadow (flush-shadow = 1-cycle registered copy of FlushQ102H), or on a push attempt with CountQ == DEPTH. Cleared only by reset.

## Timing
- Reset (async assert, sync-to-Clock deassert by system): WrPtr=RdPtr=0, InflightQ=0, ErrQ=0, CountQ=0, DecValidQ101H=0, FetchReadyQ100H=1 from the first edge after release.
- Fetch issued cycle N (Q100H), response cycle N+1 (Q101H), pushed at edge ending N+1, DecValidQ101H high in cycle N+2. Minimum fetch-to-decode latency: 2 cycles.
- Steady state with DecReadyQ101H=1 continuously: one instruction per cycle; FetchReadyQ100H stays 1.
- Decode stall: FetchReadyQ100H drops the cycle after CountQ+InflightQ reaches DEPTH; no response is ever lost.
- Flush cycle F: DecValidQ101H=0 in F+1; FetchReadyQ100H=1 in F+1; first target-path instruction visible in F+3.
- Pointer wrap: entry DEPTH-1 followed by entry 0 with no bubble.

## Test plan
- Reset then stream PCs 0x0,0x4,...,0x3C with DecReadyQ101H=1 -> DecPcQ101H sequence 0x0..0x3C in order, one per cycle from cycle 3, FetchReadyQ100H never 0, ErrQ=0.
- DecReadyQ101H=0 from reset, DEPTH=4 -> exactly 4 entries pushed, CountQ=4, FetchReadyQ100H=0; release ready -> PCs 0x0,0x4,0x8,0xC drained in order, fetch resumes.
- Queue holding 3 entries plus one in flight, FlushQ102H=1 with FetchValidQ101H=1 -> next cycle CountQ=0, DecValidQ101H=0; target PC 0x100 fetched in F+1 appears at DecPcQ101H in F+3, ErrQ=0.
- Simultaneous push and pop at CountQ=2 for 10 cycles with wrap -> CountQ stays 2, data order preserved across wrap.
- FetchValidQ101H=1 with no prior fetch issued (not a flush shadow) -> no push, ErrQ=1 and stays 1 until Rst low.
- Assert Rst low mid-stream with CountQ=3 -> immediately CountQ=0, DecValidQ101H=0, ErrQ=0; after release streaming restarts from IF reset PC.
